// File: rtl/fp_pkg.sv
// Shared definitions for the sequential FP32 adder/subtractor.
//   - FSM state encodings (IDLE, ALIGN, ADD, NORM, ROUND, DONE)
//   - IEEE-754 single-precision constants (bias, all-ones exponent, quiet NaN)
//   - bit positions and one-hot masks for the {invalid, overflow, underflow, inexact} flags
//   - per-operand classification record produced by fp32_classify
package fp_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ALIGN = 3'd1;
  localparam logic [2:0] ST_ADD   = 3'd2;
  localparam logic [2:0] ST_NORM  = 3'd3;
  localparam logic [2:0] ST_ROUND = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam int          BIAS    = 127;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  localparam int FLAG_INVALID_BIT   = 3;
  localparam int FLAG_OVERFLOW_BIT  = 2;
  localparam int FLAG_UNDERFLOW_BIT = 1;
  localparam int FLAG_INEXACT_BIT   = 0;

  localparam logic [3:0] FL_INVALID   = 4'(1 << FLAG_INVALID_BIT);
  localparam logic [3:0] FL_OVERFLOW  = 4'(1 << FLAG_OVERFLOW_BIT);
  localparam logic [3:0] FL_UNDERFLOW = 4'(1 << FLAG_UNDERFLOW_BIT);
  localparam logic [3:0] FL_INEXACT   = 4'(1 << FLAG_INEXACT_BIT);

  typedef struct packed {
    logic is_zero;  // exponent field zero: true zero or denormal, both handled as zero
    logic is_inf;
    logic is_nan;
    logic hidden;   // implicit leading one of a normal number
  } fp_class_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 operand classifier.
// Ports:
//   val  in   32  FP32 operand
//   cls  out  fp_class_t {is_zero, is_inf, is_nan, hidden}
module fp32_classify
  import fp_pkg::*;
(
  input  logic [31:0] val,
  output fp_class_t   cls
);

  logic [7:0] exp_f;
  logic       frac_nz;

  assign exp_f   = val[30:23];
  assign frac_nz = |val[22:0];

  assign cls.is_zero = (exp_f == 8'h00);
  assign cls.is_inf  = (exp_f == EXP_MAX) && !frac_nz;
  assign cls.is_nan  = (exp_f == EXP_MAX) && frac_nz;
  assign cls.hidden  = (exp_f != 8'h00);

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision adder/subtractor, round-to-nearest-even.
// Alignment and normalisation move one bit per cycle; the large/small operand
// swap, special-case detection and operand classification happen at capture.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. Valid never depends on ready; once out_valid is raised, out_res and
// out_flags hold until the transfer. in_ready is high only in IDLE.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   operand pair valid
//   in_ready   out  1   idle, can accept operands
//   in_a       in   32  operand a
//   in_b       in   32  operand b
//   in_op      in   1   0: a+b, 1: a-b
//   out_valid  out  1   result valid, held until accepted
//   out_ready  in   1   consumer accepts result
//   out_res    out  32  result
//   out_flags  out  4   {invalid, overflow, underflow, inexact}
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter int EXP_W     = 8,
  parameter int MAN_W     = 23,
  parameter int ALIGN_CAP = 26
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   in_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_res,
  output logic [3:0]             out_flags
);

  localparam int W     = EXP_W + MAN_W + 1;
  // Magnitude layout: [MAN_W+3] carry slot, [MAN_W+2] hidden, fraction, G, R.
  localparam int MAG_W = MAN_W + 4;

  localparam logic [EXP_W-1:0] CAP     = EXP_W'(ALIGN_CAP);
  localparam logic [EXP_W-1:0] CNT_ONE = EXP_W'(1);
  localparam logic [EXP_W:0]   EXP_ONE = (EXP_W+1)'(1);
  localparam logic [EXP_W:0]   EXP_OVF = {1'b0, EXP_MAX};

  logic [2:0]       state;
  logic             sign_l;
  logic             sign_s;
  logic [EXP_W:0]   exp_r;
  logic [MAG_W-1:0] mag_l;    // large operand, then the running result
  logic [MAG_W-1:0] mag_s;
  logic             sticky;
  logic [EXP_W-1:0] cnt;
  logic [W-1:0]     res_r;
  logic [3:0]       flags_r;

  // ---------------- capture path ----------------
  fp_class_t cls_a;
  fp_class_t cls_b;

  fp32_classify u_cls_a (.val(in_a), .cls(cls_a));
  fp32_classify u_cls_b (.val(in_b), .cls(cls_b));

  logic         sign_a;
  logic         sign_b_eff;
  logic [W-2:0] key_a;
  logic [W-2:0] key_b;
  logic         swap;
  logic [W-2:0] key_big;
  logic [W-2:0] key_small;
  logic         hid_big;
  logic         hid_small;
  logic         spec_nan;
  logic         spec_inf;
  logic [W-1:0] inf_res;

  assign sign_a     = in_a[W-1];
  assign sign_b_eff = in_b[W-1] ^ in_op;

  // Denormals collapse to zero magnitude before the ordering compare.
  assign key_a     = cls_a.is_zero ? '0 : in_a[W-2:0];
  assign key_b     = cls_b.is_zero ? '0 : in_b[W-2:0];
  assign swap      = (key_b > key_a);
  assign key_big   = swap ? key_b : key_a;
  assign key_small = swap ? key_a : key_b;
  assign hid_big   = swap ? cls_b.hidden : cls_a.hidden;
  assign hid_small = swap ? cls_a.hidden : cls_b.hidden;

  assign spec_nan = cls_a.is_nan || cls_b.is_nan ||
                    (cls_a.is_inf && cls_b.is_inf && (sign_a != sign_b_eff));
  assign spec_inf = cls_a.is_inf || cls_b.is_inf;
  assign inf_res  = cls_a.is_inf ? {sign_a, EXP_MAX, {MAN_W{1'b0}}}
                                 : {sign_b_eff, EXP_MAX, {MAN_W{1'b0}}};

  // ---------------- add / round datapath ----------------
  // The sticky bit takes part in the subtraction so that a borrow from the
  // discarded tail of S is reflected in G/R; the new LSB becomes the sticky.
  logic [MAG_W:0]   sum_ext;
  logic             rnd_up;
  logic [MAN_W+1:0] man_rnd;
  logic [EXP_W:0]   exp_rnd;
  logic [MAN_W-1:0] frac_rnd;
  logic             inexact_pre;

  assign sum_ext = (sign_l == sign_s) ? ({mag_l, 1'b0} + {mag_s, sticky})
                                      : ({mag_l, 1'b0} - {mag_s, sticky});

  assign rnd_up      = mag_l[1] && (mag_l[0] || sticky || mag_l[2]);
  assign man_rnd     = {1'b0, mag_l[MAN_W+2:2]} + (MAN_W+2)'(rnd_up);
  assign exp_rnd     = exp_r + (EXP_W+1)'(man_rnd[MAN_W+1]);
  assign frac_rnd    = man_rnd[MAN_W+1] ? man_rnd[MAN_W:1] : man_rnd[MAN_W-1:0];
  assign inexact_pre = mag_l[1] || mag_l[0] || sticky;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      sign_l  <= 1'b0;
      sign_s  <= 1'b0;
      exp_r   <= '0;
      mag_l   <= '0;
      mag_s   <= '0;
      sticky  <= 1'b0;
      cnt     <= '0;
      res_r   <= '0;
      flags_r <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (spec_nan) begin
              res_r   <= QNAN;
              flags_r <= FL_INVALID;
              state   <= ST_DONE;
            end else if (spec_inf) begin
              res_r   <= inf_res;
              flags_r <= '0;
              state   <= ST_DONE;
            end else begin
              sign_l <= swap ? sign_b_eff : sign_a;
              sign_s <= swap ? sign_a : sign_b_eff;
              exp_r  <= {1'b0, key_big[W-2:MAN_W]};
              mag_l  <= {1'b0, hid_big, key_big[MAN_W-1:0], 2'b00};
              mag_s  <= {1'b0, hid_small, key_small[MAN_W-1:0], 2'b00};
              sticky <= 1'b0;
              cnt    <= key_big[W-2:MAN_W] - key_small[W-2:MAN_W];
              state  <= ST_ALIGN;
            end
          end
        end

        ST_ALIGN: begin
          if (cnt > CAP) begin
            // Far below R: only its non-zeroness matters.
            sticky <= sticky | (|mag_s);
            mag_s  <= '0;
            cnt    <= '0;
            state  <= ST_ADD;
          end else if (cnt != '0) begin
            mag_s  <= mag_s >> 1;
            sticky <= sticky | mag_s[0];
            cnt    <= cnt - CNT_ONE;
          end else begin
            state <= ST_ADD;
          end
        end

        ST_ADD: begin
          mag_l  <= sum_ext[MAG_W:1];
          sticky <= sum_ext[0];
          state  <= ST_NORM;
        end

        ST_NORM: begin
          if ({mag_l, sticky} == '0) begin
            // Exact zero: negative only when both addends were negative zeros.
            res_r   <= {sign_l & sign_s, {(W-1){1'b0}}};
            flags_r <= '0;
            state   <= ST_DONE;
          end else if (mag_l[MAG_W-1]) begin
            mag_l  <= mag_l >> 1;
            sticky <= sticky | mag_l[0];
            exp_r  <= exp_r + EXP_ONE;
            state  <= ST_ROUND;
          end else if (mag_l[MAG_W-2]) begin
            state <= ST_ROUND;
          end else if (exp_r <= EXP_ONE) begin
            // Result would be denormal: flush.
            res_r   <= {sign_l, {(W-1){1'b0}}};
            flags_r <= FL_UNDERFLOW | FL_INEXACT;
            state   <= ST_DONE;
          end else begin
            mag_l <= mag_l << 1;
            exp_r <= exp_r - EXP_ONE;
          end
        end

        ST_ROUND: begin
          if (exp_rnd >= EXP_OVF) begin
            res_r   <= {sign_l, EXP_MAX, {MAN_W{1'b0}}};
            flags_r <= FL_OVERFLOW | FL_INEXACT;
          end else begin
            res_r   <= {sign_l, exp_rnd[EXP_W-1:0], frac_rnd};
            flags_r <= inexact_pre ? FL_INEXACT : 4'h0;
          end
          state <= ST_DONE;
        end

        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_res   = res_r;
  assign out_flags = flags_r;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq. Expected results come from an exact
// wide-integer model of IEEE-754 addition (RNE, denormal flush); each
// directed vector also carries a hand-computed result that pins the model.
module tb_fp_addsub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [3:0]  out_flags;

  fp_addsub_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_flags (out_flags)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];  // {flags, result}

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;   // -1: latency not checked
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  // Operands become exact integers in units of 2^-149; the sum is rounded to
  // 24 significant bits with round-to-nearest-even.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic sa, sb, sgn, inexact;
    logic a_nan, b_nan, a_inf, b_inf;
    logic [279:0] ma, mb, mag, rem, half;
    logic [24:0] sig;
    int p, e, sh;
    sa = a[31];
    sb = b[31] ^ op;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan || (a_inf && b_inf && sa != sb)) return {4'b1000, 32'h7FC00000};
    if (a_inf) return {4'b0000, sa, 8'hFF, 23'h0};
    if (b_inf) return {4'b0000, sb, 8'hFF, 23'h0};
    ma = (a[30:23] == 0) ? '0 : (280'({1'b1, a[22:0]}) << (int'(a[30:23]) - 1));
    mb = (b[30:23] == 0) ? '0 : (280'({1'b1, b[22:0]}) << (int'(b[30:23]) - 1));
    if (sa == sb) begin
      mag = ma + mb; sgn = sa;
    end else if (ma >= mb) begin
      mag = ma - mb; sgn = sa;
    end else begin
      mag = mb - ma; sgn = sb;
    end
    if (mag == 0) return {4'b0000, sa & sb, 31'h0};
    p = 0;
    for (int i = 0; i < 280; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e < 1) return {4'b0011, sgn, 31'h0};
    sh = p - 23;
    sig = 25'(mag >> sh);
    rem = mag & ((280'(1) << sh) - 280'(1));
    inexact = (rem != 0);
    if (sh > 0) begin
      half = 280'(1) << (sh - 1);
      if (rem > half || (rem == half && sig[0])) sig = sig + 25'd1;
    end
    if (sig[24]) begin
      sig = sig >> 1;
      e = e + 1;
    end
    if (e >= 255) return {4'b0101, sgn, 8'hFF, 23'h0};
    return {3'b000, inexact, sgn, e[7:0], sig[22:0]};
  endfunction

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output: got %h required no output", {out_flags, out_res});
      end else begin
        check("result", {out_flags, out_res}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic op);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 36'(in_ready), 36'(1));
    in_a = a;
    in_b = b;
    in_op = op;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy_in_ready", 36'(in_ready), 36'(0));
  endtask

  task automatic run_vec(input vec_t v);
    logic [35:0] m;
    int n;
    m = model(v.a, v.b, v.op);
    check("model_pin", m, {v.flags, v.res});
    exp_q.push_back(m);
    drive(v.a, v.b, v.op);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 36'(out_valid), 36'(1));
      exp_q.delete();
      rst = 1'b1;
      #1;
      rst = 1'b0;
    end else begin
      if (v.lat >= 0) check("latency", 36'(n), 36'(v.lat));
      n = 0;
      while (out_valid && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("idle_after_accept", 36'(in_ready), 36'(1));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [35:0] m;
    int n;
    int seen;

    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0, 4};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0, -1};
    vecs[2]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1, 28};
    vecs[3]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1, -1};
    vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5, 4};
    vecs[5]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8, -1};
    vecs[6]  = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 4'h1, 28};
    vecs[7]  = '{32'h7F000000, 32'h3F800000, 1'b0, 32'h7F000000, 4'h1, 4};
    vecs[8]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'h0, 5};
    vecs[9]  = '{32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 4'h0, 6};
    vecs[10] = '{32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 4'h0, -1};
    vecs[11] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0, -1};
    vecs[12] = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'h0, -1};
    vecs[13] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8, -1};
    vecs[14] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'h0, -1};
    vecs[15] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'h0, -1};
    vecs[16] = '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'h0, -1};
    vecs[17] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'h3, -1};
    vecs[18] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'h0, 6};
    vecs[19] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'h1, -1};
    vecs[20] = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'h0, -1};
    vecs[21] = '{32'h3F800000, 32'h0C800000, 1'b1, 32'h3F800000, 4'h1, -1};
    vecs[22] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 4'h5, -1};
    vecs[23] = '{32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 4'h0, -1};

    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 36'(in_ready), 36'(1));
    check("reset_out_valid", 36'(out_valid), 36'(0));
    check("reset_out", {out_flags, out_res}, 36'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) run_vec(vecs[i]);

    // Backpressure: result and flags must hold while the consumer stalls.
    out_ready = 1'b0;
    m = model(32'h3F800000, 32'h33800000, 1'b0);
    check("model_pin_hold", m, {4'h1, 32'h3F800000});
    exp_q.push_back(m);
    drive(32'h3F800000, 32'h33800000, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_out", {out_flags, out_res}, m);
      check("hold_out_valid", 36'(out_valid), 36'(1));
      check("hold_in_ready", 36'(in_ready), 36'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("hold_released", 36'(out_valid), 36'(0));
    check("hold_queue_drained", 36'(exp_q.size()), 36'(0));

    // Reset in the middle of a 24-step alignment abandons the operation.
    drive(32'h4B800000, 32'h3F800000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 36'(out_valid), 36'(0));
    check("midrst_in_ready", 36'(in_ready), 36'(1));
    check("midrst_out", {out_flags, out_res}, 36'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("midrst_no_emit", 36'(seen), 36'(0));
    check("midrst_idle", 36'(in_ready), 36'(1));

    // Operation after the abandoned one completes normally.
    run_vec(vecs[0]);
    run_vec(vecs[9]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: got no completion required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
